// File: rtl/frame_pad_inserter_pkg.sv
// Shared ISP constants for the frame pad inserter.
// Holds the pad-mode encodings, the FSM state codes and the border helper.
package frame_pad_inserter_pkg;

  typedef logic [1:0] pad_mode_t;
  typedef logic [2:0] state_t;

  localparam pad_mode_t PAD_ZERO  = 2'd0;
  localparam pad_mode_t PAD_CONST = 2'd1;
  localparam pad_mode_t PAD_EDGE  = 2'd2;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_TOP    = 3'd1;
  localparam state_t ST_LEFT   = 3'd2;
  localparam state_t ST_BODY   = 3'd3;
  localparam state_t ST_RIGHT  = 3'd4;
  localparam state_t ST_BOTTOM = 3'd5;
  localparam state_t ST_DONE   = 3'd6;

  function automatic int border_of(input int kernel_size);
    return (kernel_size - 1) / 2;
  endfunction

endpackage

// File: rtl/frame_pad_inserter_pad_counter.sv
// Raster position of the next output pixel to be transferred.
// x wraps at the end of a padded row; y saturates one past the last padded row.
module pad_counter #(
  parameter int X_COUNT = 6,
  parameter int Y_COUNT = 5,
  parameter int XW      = 3,
  parameter int YW      = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          advance,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          row_end
);

  localparam logic [XW-1:0] X_LAST = XW'(X_COUNT - 1);
  localparam logic [YW-1:0] Y_END  = YW'(Y_COUNT);

  assign row_end = (x == X_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x <= '0;
      y <= '0;
    end else if (clear) begin
      x <= '0;
      y <= '0;
    end else if (advance) begin
      if (row_end) begin
        x <= '0;
        if (y != Y_END) y <= y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

endmodule

// File: rtl/frame_pad_inserter.sv
// Surrounds each incoming frame with a B-pixel border (zero, constant or edge-replicated).
// State and counters track transferred pixels; the registered output holds the pixel at that position.
module frame_pad_inserter
  import frame_pad_inserter_pkg::*;
#(
  parameter int WIDTH       = 320,
  parameter int HEIGHT      = 240,
  parameter int KERNEL_SIZE = 7,
  parameter int CHANNELS    = 3,
  parameter int DATA_W      = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         newFrame,
  input  logic [1:0]                   padMode,
  input  logic [CHANNELS*DATA_W-1:0]   padValue,
  input  logic                         iValid,
  input  logic [CHANNELS*DATA_W-1:0]   iData,
  output logic                         oReady,
  output logic                         oValid,
  output logic [CHANNELS*DATA_W-1:0]   oData,
  input  logic                         iReady,
  output logic                         oDone,
  output logic                         oBusy
);

  localparam int PW = CHANNELS * DATA_W;
  localparam int B  = border_of(KERNEL_SIZE);
  localparam int TW = WIDTH + 2 * B;
  localparam int TH = HEIGHT + 2 * B;
  localparam int XW = $clog2(TW + 1);
  localparam int YW = $clog2(TH + 1);

  localparam logic [XW-1:0] X_LEFT_LAST = XW'(B - 1);
  localparam logic [XW-1:0] X_BODY_LAST = XW'(B + WIDTH - 1);
  localparam logic [YW-1:0] Y_TOP_LAST  = YW'(B - 1);
  localparam logic [YW-1:0] Y_ACT_LAST  = YW'(B + HEIGHT - 1);
  localparam logic [YW-1:0] Y_BOT_LAST  = YW'(TH - 1);

  state_t          state, nxt_state, tgt_state;
  pad_mode_t       mode_cap;
  logic [PW-1:0]   pad_cap, edge_hold, pad_pixel, load_data;
  logic            edge_held, mode_edge, load_valid;
  logic            xfer, can_load, accept, start;
  logic [XW-1:0]   x;
  logic [YW-1:0]   y;
  logic            row_end;

  assign xfer     = oValid && iReady;
  assign can_load = !oValid || iReady;
  assign start    = (state == ST_IDLE) && newFrame;
  assign accept   = oReady && iValid;
  assign oDone    = (state == ST_DONE);
  assign oBusy    = (state != ST_IDLE) && (state != ST_DONE);

  pad_counter #(
    .X_COUNT (TW),
    .Y_COUNT (TH),
    .XW      (XW),
    .YW      (YW)
  ) u_pad_counter (
    .clk     (clk),
    .reset   (reset),
    .clear   (start),
    .advance (xfer),
    .x       (x),
    .y       (y),
    .row_end (row_end)
  );

  always_comb begin
    nxt_state = state;
    case (state)
      ST_TOP:    if (row_end && y == Y_TOP_LAST) nxt_state = ST_LEFT;
      ST_LEFT:   if (x == X_LEFT_LAST) nxt_state = ST_BODY;
      ST_BODY:   if (x == X_BODY_LAST) nxt_state = ST_RIGHT;
      ST_RIGHT:  if (row_end) nxt_state = (y == Y_ACT_LAST) ? ST_BOTTOM : ST_LEFT;
      ST_BOTTOM: if (row_end && y == Y_BOT_LAST) nxt_state = ST_DONE;
      default:   nxt_state = state;
    endcase
  end

  // The pixel to load is the one at the position that follows any transfer happening now.
  assign tgt_state = xfer ? nxt_state : state;
  assign pad_pixel = (mode_cap == PAD_CONST) ? pad_cap : '0;
  assign mode_edge = (mode_cap == PAD_EDGE);

  always_comb begin
    oReady     = 1'b0;
    load_valid = 1'b0;
    load_data  = pad_pixel;
    if (can_load) begin
      case (tgt_state)
        ST_TOP, ST_BOTTOM: load_valid = 1'b1;
        ST_LEFT: begin
          if (mode_edge && !edge_held) begin
            oReady     = 1'b1;
            load_valid = iValid;
            load_data  = iData;
          end else begin
            load_valid = 1'b1;
            load_data  = mode_edge ? edge_hold : pad_pixel;
          end
        end
        ST_BODY: begin
          if (mode_edge && edge_held) begin
            load_valid = 1'b1;
            load_data  = edge_hold;
          end else begin
            oReady     = 1'b1;
            load_valid = iValid;
            load_data  = iData;
          end
        end
        ST_RIGHT: begin
          load_valid = 1'b1;
          load_data  = mode_edge ? edge_hold : pad_pixel;
        end
        default: load_valid = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (newFrame) state <= ST_TOP;
        ST_DONE: state <= ST_IDLE;
        default: if (xfer) state <= nxt_state;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_cap <= PAD_ZERO;
      pad_cap  <= '0;
    end else if (start) begin
      mode_cap <= padMode;
      pad_cap  <= padValue;
    end
  end

  // edge_hold doubles as first-pixel store (left pads, body 0) and last-pixel store (right pads).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      edge_hold <= '0;
      edge_held <= 1'b0;
    end else begin
      if (start)
        edge_held <= 1'b0;
      else if (accept && tgt_state == ST_LEFT)
        edge_held <= 1'b1;
      else if (can_load && tgt_state == ST_BODY && mode_edge && edge_held)
        edge_held <= 1'b0;
      if (accept) edge_hold <= iData;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      oValid <= 1'b0;
      oData  <= '0;
    end else if (can_load) begin
      oValid <= load_valid;
      if (load_valid) oData <= load_data;
    end
  end

endmodule

// File: tb/tb_frame_pad_inserter.sv
// Self-checking bench for frame_pad_inserter on a 4x3 frame with a 3x3 kernel.
// Whole-frame vectors come from a table; reset and idle behaviour use hand-written sequences.
module tb_frame_pad_inserter;

  localparam int WIDTH = 4, HEIGHT = 3, KERNEL = 3, CHANNELS = 3, DATA_W = 8;
  localparam int PW = CHANNELS * DATA_W;
  localparam int B = 1, TW = WIDTH + 2 * B, TH = HEIGHT + 2 * B;
  localparam int NPIX = TW * TH, NIN = WIDTH * HEIGHT, NVEC = 7;

  typedef logic [TW-1:0][PW-1:0] row_t;
  typedef struct packed {
    logic [1:0]    mode;
    logic [PW-1:0] pad;
    logic          stall;
    logic          glitch;
    row_t          exp_row1;
  } frame_vec_t;

  logic          clk = 1'b0;
  logic          reset, newFrame, iValid, oReady, oValid, iReady, oDone, oBusy;
  logic [1:0]    padMode;
  logic [PW-1:0] padValue, iData, oData;

  int            checks = 0;
  int            errors = 0;
  logic [PW-1:0] exp_q[$];
  frame_vec_t    vecs[NVEC];

  always #5 clk = ~clk;

  frame_pad_inserter #(
    .WIDTH(WIDTH), .HEIGHT(HEIGHT), .KERNEL_SIZE(KERNEL), .CHANNELS(CHANNELS), .DATA_W(DATA_W)
  ) dut (
    .clk(clk), .reset(reset), .newFrame(newFrame), .padMode(padMode), .padValue(padValue),
    .iValid(iValid), .iData(iData), .oReady(oReady), .oValid(oValid), .oData(oData),
    .iReady(iReady), .oDone(oDone), .oBusy(oBusy)
  );

  function automatic row_t makeRow(input logic [PW-1:0] a, b, c, d, e, f);
    row_t r;
    r[0] = a; r[1] = b; r[2] = c; r[3] = d; r[4] = e; r[5] = f;
    return r;
  endfunction

  // Reference model: inputs are 1..NIN in arrival order.
  function automatic logic [PW-1:0] expPixel(input logic [1:0] mode, input logic [PW-1:0] pad,
                                             input int r, input int c);
    logic [PW-1:0] padpix;
    int a;
    padpix = (mode == 2'd1) ? pad : '0;
    if (r < B || r >= B + HEIGHT) return padpix;
    a = r - B;
    if (c < B) return (mode == 2'd2) ? PW'(a * WIDTH + 1) : padpix;
    if (c >= B + WIDTH) return (mode == 2'd2) ? PW'(a * WIDTH + WIDTH) : padpix;
    return PW'(a * WIDTH + (c - B) + 1);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic stall, input int in_idx);
    iReady = stall ? 1'($urandom_range(0, 1)) : 1'b1;
    iValid = (in_idx < NIN) && (stall ? 1'($urandom_range(0, 1)) : 1'b1);
    iData  = PW'(in_idx + 1);
  endtask

  task automatic runFrame(input frame_vec_t v, input int abort_after, output int xfers);
    int            in_idx, done_cnt;
    logic          finished, aborted, prev_stall;
    logic [PW-1:0] prev_data, exp;
    row_t          row1;
    @(negedge clk);
    padMode  = v.mode;
    padValue = v.pad;
    newFrame = 1'b1;
    iValid   = 1'b0;
    iReady   = 1'b1;
    exp_q.delete();
    for (int r = 0; r < TH; r++)
      for (int c = 0; c < TW; c++) exp_q.push_back(expPixel(v.mode, v.pad, r, c));
    in_idx = 0; xfers = 0; done_cnt = 0; finished = 0; aborted = 0;
    prev_stall = 0; prev_data = '0; row1 = '0;
    for (int cyc = 0; cyc < 2000 && !finished && !aborted; cyc++) begin
      @(negedge clk);
      newFrame = v.glitch && (cyc == 8);
      if (v.glitch && cyc == 8) begin
        padMode  = ~v.mode;
        padValue = 24'h5A5A5A;
      end
      applyStimulus(v.stall, in_idx);
      #1;
      if (cyc == 0) checkOutput("busy_after_start", 32'(oBusy), 32'd1);
      if (prev_stall) begin
        checkOutput("stall_valid_hold", 32'(oValid), 32'd1);
        checkOutput("stall_data_hold", 32'(oData), 32'(prev_data));
      end
      if (oValid && iReady) begin
        if (exp_q.size() == 0) checkOutput("extra_output", 32'(xfers), 32'(NPIX));
        else begin
          exp = exp_q.pop_front();
          checkOutput($sformatf("pixel%0d", xfers), 32'(oData), 32'(exp));
        end
        if (xfers / TW == 1) row1[xfers % TW] = oData;
        xfers++;
      end
      if (oReady && iValid) in_idx++;
      prev_stall = oValid && !iReady;
      prev_data  = oData;
      if (oDone) begin
        done_cnt++;
        checkOutput("busy_at_done", 32'(oBusy), 32'd0);
        finished = 1;
      end
      if (abort_after > 0 && xfers >= abort_after) aborted = 1;
    end
    if (!aborted) begin
      checkOutput("frame_complete", 32'(finished), 32'd1);
      checkOutput("done_count", 32'(done_cnt), 32'd1);
      checkOutput("pixel_count", 32'(xfers), 32'(NPIX));
      checkOutput("inputs_consumed", 32'(in_idx), 32'(NIN));
      for (int c = 0; c < TW; c++)
        checkOutput($sformatf("row1_px%0d", c), 32'(row1[c]), 32'(v.exp_row1[c]));
      @(negedge clk);
      #1;
      checkOutput("done_pulse_width", 32'(oDone), 32'd0);
    end
  endtask

  initial begin
    int n;
    vecs[0] = '{mode: 2'd0, pad: 24'h123456, stall: 1'b0, glitch: 1'b0, exp_row1: makeRow(0, 1, 2, 3, 4, 0)};
    vecs[1] = '{mode: 2'd2, pad: 24'h111111, stall: 1'b0, glitch: 1'b0, exp_row1: makeRow(1, 1, 2, 3, 4, 4)};
    vecs[2] = '{mode: 2'd1, pad: 24'hABCDEF, stall: 1'b0, glitch: 1'b0,
                exp_row1: makeRow(24'hABCDEF, 1, 2, 3, 4, 24'hABCDEF)};
    vecs[3] = '{mode: 2'd0, pad: 24'h000000, stall: 1'b1, glitch: 1'b0, exp_row1: makeRow(0, 1, 2, 3, 4, 0)};
    vecs[4] = '{mode: 2'd3, pad: 24'h777777, stall: 1'b0, glitch: 1'b0, exp_row1: makeRow(0, 1, 2, 3, 4, 0)};
    vecs[5] = '{mode: 2'd2, pad: 24'h222222, stall: 1'b1, glitch: 1'b1, exp_row1: makeRow(1, 1, 2, 3, 4, 4)};
    vecs[6] = '{mode: 2'd1, pad: 24'hABCDEF, stall: 1'b1, glitch: 1'b1,
                exp_row1: makeRow(24'hABCDEF, 1, 2, 3, 4, 24'hABCDEF)};

    reset = 1'b1; newFrame = 1'b0; padMode = 2'd0; padValue = '0;
    iValid = 1'b0; iData = '0; iReady = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset_oValid", 32'(oValid), 32'd0);
    checkOutput("reset_oData", 32'(oData), 32'd0);
    checkOutput("reset_oReady", 32'(oReady), 32'd0);
    checkOutput("reset_oDone", 32'(oDone), 32'd0);
    checkOutput("reset_oBusy", 32'(oBusy), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      $display("[TB] frame vector %0d mode=%0d stall=%0d glitch=%0d", i, vecs[i].mode, vecs[i].stall, vecs[i].glitch);
      runFrame(vecs[i], 0, n);
    end

    // Mid-frame reset after 10 transfers, then idle without newFrame, then a clean frame.
    runFrame(vecs[0], 10, n);
    checkOutput("xfers_before_reset", 32'(n), 32'd10);
    #2 reset = 1'b1;
    #1;
    checkOutput("midrst_oValid", 32'(oValid), 32'd0);
    checkOutput("midrst_oData", 32'(oData), 32'd0);
    checkOutput("midrst_oReady", 32'(oReady), 32'd0);
    checkOutput("midrst_oDone", 32'(oDone), 32'd0);
    checkOutput("midrst_oBusy", 32'(oBusy), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      iValid = 1'b1; iReady = 1'b1; iData = 24'h000099;
      #1;
      checkOutput("idle_no_output", 32'(oValid), 32'd0);
      checkOutput("idle_not_ready", 32'(oReady), 32'd0);
      checkOutput("idle_not_busy", 32'(oBusy), 32'd0);
    end
    runFrame(vecs[0], 0, n);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/frame_pad_inserter.md
FRAME_PAD_INSERTER -- requirements
Module: frame_pad_inserter

Interface
REQ-001 SHALL have parameter WIDTH, default 320: active pixels per input row.
REQ-002 SHALL have parameter HEIGHT, default 240: active rows per input frame.
REQ-003 SHALL have parameter KERNEL_SIZE, default 7: odd and >=3; border B = (KERNEL_SIZE-1)/2.
REQ-004 SHALL have parameter CHANNELS, default 3, and parameter DATA_W, default 8; pixel width PW = CHANNELS*DATA_W.
REQ-005 SHALL have port clk, input, 1: the single clock.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port newFrame, input, 1: one-cycle frame start pulse.
REQ-008 SHALL have port padMode, input, 2: 0 = zero, 1 = constant, 2 = edge-replicate; 3 is reserved and treated as 0.
REQ-009 SHALL have port padValue, input, PW: the constant used by mode 1.
REQ-010 SHALL have ports iValid (input, 1), iData (input, PW) and oReady (output, 1): upstream pixel handshake.
REQ-011 SHALL have ports oValid (output, 1), oData (output, PW) and iReady (input, 1): downstream pixel handshake.
REQ-012 SHALL have port oDone, output, 1: one-cycle pulse when a frame completes.
REQ-013 SHALL have port oBusy, output, 1: high from frame start until oDone.

Function
REQ-014 SHALL emit exactly (HEIGHT+2B)*(WIDTH+2B) output pixels per frame, in raster order.
REQ-015 SHALL fill the top B rows and bottom B rows entirely with the pad pixel: 0 in modes 0, 2 and 3; padValue in mode 1.
REQ-016 SHALL emit, for each active row, B left pad pixels, then WIDTH input pixels in arrival order, then B right pad pixels.
REQ-017 SHALL, in mode 2, use the row's first input pixel for the left pads and the row's last input pixel for the right pads; modes 0, 1 and 3 use the REQ-015 pad pixel.
REQ-018 SHALL sample padMode and padValue on newFrame; changes during a frame SHALL be ignored.
REQ-019 SHALL use the states IDLE, TOP, LEFT, BODY, RIGHT, BOTTOM and DONE.
REQ-020 SHALL transition IDLE->TOP on newFrame.
REQ-021 SHALL transition TOP->LEFT after B*(WIDTH+2B) pixels have been transferred.
REQ-022 SHALL transition LEFT->BODY after B pads, BODY->RIGHT after WIDTH pixels, and RIGHT->LEFT after B pads unless this was active row HEIGHT-1, in which case RIGHT->BOTTOM.
REQ-023 SHALL transition BOTTOM->DONE after the last pad transfers, and DONE->IDLE after one cycle.
REQ-024 SHALL count a pixel as transferred only on a cycle where oValid && iReady; all counters SHALL advance only on transfers.
REQ-025 SHALL register oData and oValid; an accepted input appears on oData on the following cycle.
REQ-026 SHALL hold oValid and oData stable while oValid && !iReady.
REQ-027 SHALL assert oReady only in BODY, or in LEFT with mode 2 before the first pixel of the row is captured, and only when the output register is empty or transferring.
REQ-028 SHALL, in mode 2, accept the row's first pixel in LEFT, emit it as the B left pads, and then emit it once more as body pixel 0 without re-accepting it.
REQ-029 SHALL ignore newFrame when not in IDLE.
REQ-030 SHALL ignore iValid outside the oReady window; no input is consumed there.
REQ-031 SHALL generate oDone in the same cycle as the DONE state, and SHALL drop oBusy in that cycle.
REQ-032 SHALL size x/y counters as $clog2(WIDTH+2B+1) and $clog2(HEIGHT+2B+1) bits, and SHALL compare them without wrap-around.

Reset
REQ-033 SHALL, on reset assertion at any time including mid-frame, immediately force state IDLE, all counters to 0, oValid=0, oData=0, oReady=0, oDone=0 and oBusy=0.
REQ-034 SHALL force the captured mode to 0 and the edge-hold register to 0 on reset.
REQ-035 SHALL require a fresh newFrame after reset release before any output is produced.

Structure
REQ-036 SHALL place the pad-mode encodings and the state enumeration in the shared ISP parameter package.
REQ-037 SHALL keep the datapath in one module; a sub-module named pad_counter SHALL hold the x/y raster counters.

Verification
REQ-038 SHALL cover mode 0 with WIDTH=4, HEIGHT=3, K=3, iReady=1 and inputs 1..12 -> 30 outputs; row 0 and row 4 all zero; row 1 = 0,1,2,3,4,0; oDone once.
REQ-039 SHALL cover the same frame in mode 2 -> row 1 = 1,1,2,3,4,4; row 2 = 5,5,6,7,8,8; top/bottom rows zero.
REQ-040 SHALL cover mode 1 with padValue=0xABCDEF -> all 18 border pixels equal 0xABCDEF; the 12 body pixels unchanged.
REQ-041 SHALL cover iReady randomly toggled at 50% -> identical output sequence to REQ-038 with no duplicates and no drops; oData stable while stalled.
REQ-042 SHALL cover reset asserted after 10 transfers -> outputs 0 in the same cycle; the next newFrame produces a complete, correct 30-pixel frame.
REQ-043 SHALL cover newFrame pulsed mid-frame and padMode changed mid-frame -> both have no effect on the current frame.
